// File: rtl/knight_rider_monitor.sv
// Watches a bouncing single-LED bus and checks step order and per-step hold length.
// state | meaning
// SYNC  | waiting for an adjacent one-hot change to pick up the sweep
// LOCK  | tracking the sweep; every step checked for adjacency and hold length
module knight_rider_monitor #(
   parameter logic [21:0] PERIOD = 22'd15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] dataIn,
   output logic       locked,
   output logic [2:0] position,
   output logic       dirLeft,
   output logic [7:0] sweepCount,
   output logic       error,
   output logic [1:0] errCode
);

   typedef enum logic {SYNC = 1'b0, LOCK = 1'b1} state_t;

   localparam logic [21:0] HOLD_MAX = PERIOD + 22'd1;

   state_t      state_q, state_d;
   logic [7:0]  last_q, last_d;
   logic [21:0] hold_cnt_q, hold_cnt_d;
   logic [2:0]  position_q, position_d;
   logic        dir_q, dir_d;
   logic [7:0]  sweep_q, sweep_d;
   logic        error_q, error_d;
   logic [1:0]  err_code_q, err_code_d;

   logic        change, cur_oh, last_oh, step_dn, step_up;
   logic        legal, new_dir;
   logic [1:0]  fault;

   function automatic logic is_onehot(input logic [7:0] v);
      return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
   endfunction

   function automatic logic [2:0] bit_index(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++)
         if (v[i]) idx = 3'(i);
      return idx;
   endfunction

   always_comb begin
      change  = (dataIn != last_q);
      cur_oh  = is_onehot(dataIn);
      last_oh = is_onehot(last_q);
      step_dn = (dataIn == (last_q >> 1));
      step_up = (dataIn == (last_q << 1));

      // The ends of the bar reverse direction instead of shifting off.
      if (!dir_q) begin
         legal   = (last_q == 8'h01) ? (dataIn == 8'h02) : step_dn;
         new_dir = (last_q == 8'h01);
      end else begin
         legal   = (last_q == 8'h80) ? (dataIn == 8'h40) : step_up;
         new_dir = (last_q != 8'h80);
      end

      state_d    = state_q;
      last_d     = dataIn;
      position_d = position_q;
      dir_d      = dir_q;
      sweep_d    = sweep_q;
      error_d    = 1'b0;
      err_code_d = err_code_q;
      fault      = 2'd0;

      if (change)
         hold_cnt_d = 22'd1;
      else if (hold_cnt_q == HOLD_MAX)
         hold_cnt_d = hold_cnt_q;
      else
         hold_cnt_d = hold_cnt_q + 22'd1;

      case (state_q)
         SYNC: begin
            if (change && cur_oh && last_oh && (step_dn || step_up)) begin
               state_d    = LOCK;
               dir_d      = step_up;
               position_d = bit_index(dataIn);
            end
         end
         LOCK: begin
            if (change) begin
               if (!cur_oh)
                  fault = 2'd1;
               else if (!legal)
                  fault = 2'd2;
               else if (hold_cnt_q != PERIOD)
                  fault = 2'd3;
               else begin
                  dir_d      = new_dir;
                  position_d = bit_index(dataIn);
                  if (last_q == 8'h40 && dataIn == 8'h80)
                     sweep_d = sweep_q + 8'd1;
               end
            end else if (hold_cnt_q == PERIOD) begin
               fault = 2'd3;
            end
         end
         default: state_d = SYNC;
      endcase

      if (fault != 2'd0) begin
         error_d    = 1'b1;
         err_code_d = fault;
         state_d    = SYNC;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= SYNC;
         last_q     <= 8'd0;
         hold_cnt_q <= 22'd0;
         position_q <= 3'd0;
         dir_q      <= 1'b0;
         sweep_q    <= 8'd0;
         error_q    <= 1'b0;
         err_code_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         hold_cnt_q <= hold_cnt_d;
         position_q <= position_d;
         dir_q      <= dir_d;
         sweep_q    <= sweep_d;
         error_q    <= error_d;
         err_code_q <= err_code_d;
      end
   end

   assign locked     = (state_q == LOCK);
   assign position   = position_q;
   assign dirLeft    = dir_q;
   assign sweepCount = sweep_q;
   assign error      = error_q;
   assign errCode    = err_code_q;

endmodule
